// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data-memory access over a req/ack handshake with timeout abort.
// Optional MEM_ALIGN_CHECK_EN rejects word-misaligned memory ops and adds misalign_err.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       alu_res_in,
  input  logic [31:0]       store_data_in,
  input  logic [4:0]        rd_in,
  input  logic              mem_r_in,
  input  logic              mem_w_in,
  input  logic              wb_sel_in,
  input  logic              reg_w_in,
  output logic              stall_out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              out_valid,
  output logic [31:0]       wb_data_out,
  output logic [4:0]        rd_out,
  output logic              reg_w_out,
  output logic              timeout_err
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              misalign_err
`endif
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     alu_q;
  logic [4:0]      rd_q;
  logic            reg_w_q;
  logic            use_rdata_q;
  logic            misaligned;
  logic            cnt_expired;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = |alu_res_in[1:0];
`else
  assign misaligned = 1'b0;
`endif

  assign cnt_expired = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      alu_q       <= '0;
      rd_q        <= '0;
      reg_w_q     <= 1'b0;
      use_rdata_q <= 1'b0;
      stall_out   <= 1'b0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      out_valid   <= 1'b0;
      wb_data_out <= '0;
      rd_out      <= '0;
      reg_w_out   <= 1'b0;
      timeout_err <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_err <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            if ((mem_r_in || mem_w_in) && misaligned) begin
              // Rejected op retires without a write so the pipeline keeps moving.
              out_valid   <= 1'b1;
              wb_data_out <= alu_res_in;
              rd_out      <= rd_in;
              reg_w_out   <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
              misalign_err <= 1'b1;
`endif
            end else if (mem_r_in || mem_w_in) begin
              state_q     <= StAccess;
              cnt_q       <= '0;
              alu_q       <= alu_res_in;
              rd_q        <= rd_in;
              reg_w_q     <= reg_w_in;
              // Load+store is a store: read data is never used.
              use_rdata_q <= wb_sel_in && mem_r_in && !mem_w_in;
              stall_out   <= 1'b1;
              dmem_req    <= 1'b1;
              dmem_we     <= mem_w_in;
              dmem_addr   <= alu_res_in[ADDR_W-1:0];
              dmem_wdata  <= store_data_in;
            end else begin
              out_valid   <= 1'b1;
              wb_data_out <= alu_res_in;
              rd_out      <= rd_in;
              reg_w_out   <= reg_w_in && (rd_in != 5'd0);
            end
          end
        end
        StAccess: begin
          if (dmem_ack) begin
            state_q     <= StIdle;
            stall_out   <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            out_valid   <= 1'b1;
            wb_data_out <= use_rdata_q ? dmem_rdata : alu_q;
            rd_out      <= rd_q;
            reg_w_out   <= reg_w_q && (rd_q != 5'd0);
          end else if (cnt_expired) begin
            state_q     <= StIdle;
            stall_out   <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            out_valid   <= 1'b1;
            wb_data_out <= alu_q;
            rd_out      <= rd_q;
            reg_w_out   <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (TIMEOUT_CYCLES = 4).
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] alu_res_in;
  logic [31:0] store_data_in;
  logic [4:0]  rd_in;
  logic        mem_r_in;
  logic        mem_w_in;
  logic        wb_sel_in;
  logic        reg_w_in;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        out_valid;
  logic [31:0] wb_data_out;
  logic [4:0]  rd_out;
  logic        reg_w_out;
  logic        timeout_err;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(
    .TIMEOUT_CYCLES(4),
    .ADDR_W        (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .alu_res_in   (alu_res_in),
    .store_data_in(store_data_in),
    .rd_in        (rd_in),
    .mem_r_in     (mem_r_in),
    .mem_w_in     (mem_w_in),
    .wb_sel_in    (wb_sel_in),
    .reg_w_in     (reg_w_in),
    .stall_out    (stall_out),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .out_valid    (out_valid),
    .wb_data_out  (wb_data_out),
    .rd_out       (rd_out),
    .reg_w_out    (reg_w_out),
    .timeout_err  (timeout_err)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .misalign_err (misalign_err)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] rd, input logic mr, input logic mw,
                       input logic ws, input logic rw);
    in_valid      = v;
    alu_res_in    = alu;
    store_data_in = sd;
    rd_in         = rd;
    mem_r_in      = mr;
    mem_w_in      = mw;
    wb_sel_in     = ws;
    reg_w_in      = rw;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({stall_out, dmem_req, dmem_we, out_valid, reg_w_out, timeout_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 000000",
               {stall_out, dmem_req, dmem_we, out_valid, reg_w_out, timeout_err});
    end
    checks++;
    if ({dmem_addr, dmem_wdata, wb_data_out, rd_out} !== 101'b0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h %h want zeros",
               dmem_addr, dmem_wdata, wb_data_out, rd_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_alu();
    drive(1'b1, 32'h5, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if ({out_valid, reg_w_out, stall_out, dmem_req} !== 4'b1100) begin
      errors++;
      $display("FAIL alu_ctrl got %b want 1100", {out_valid, reg_w_out, stall_out, dmem_req});
    end
    checks++;
    if (wb_data_out !== 32'h5 || rd_out !== 5'd3) begin
      errors++;
      $display("FAIL alu_data got %h/%0d want 5/3", wb_data_out, rd_out);
    end
    // Back-to-back op to rd 0: reg write must be suppressed.
    drive(1'b1, 32'h9, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if (out_valid !== 1'b1 || wb_data_out !== 32'h9 || reg_w_out !== 1'b0) begin
      errors++;
      $display("FAIL alu_rd0 got v=%b d=%h w=%b want v=1 d=9 w=0",
               out_valid, wb_data_out, reg_w_out);
    end
    drive(1'b0, 32'h77, 32'h0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if (out_valid !== 1'b0 || wb_data_out !== 32'h9) begin
      errors++;
      $display("FAIL alu_idle_hold got v=%b d=%h want v=0 d=9", out_valid, wb_data_out);
    end
    // Stray ack in idle is ignored.
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || dmem_req !== 1'b0 || stall_out !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack got v=%b r=%b s=%b want 0 0 0", out_valid, dmem_req, stall_out);
    end
  endtask

  task automatic test_load();
    drive(1'b1, 32'h40, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    // Inputs change during ACCESS and must be ignored.
    drive(1'b1, 32'h99, 32'h55, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({dmem_req, dmem_we, stall_out, out_valid} !== 4'b1010 || dmem_addr !== 32'h40) begin
        errors++;
        $display("FAIL load_access[%0d] got rwsv=%b a=%h want 1010 a=40", i,
                 {dmem_req, dmem_we, stall_out, out_valid}, dmem_addr);
      end
      if (i == 2) begin
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        in_valid   = 1'b0;
      end
      tick();
    end
    dmem_ack = 1'b0;
    checks++;
    if ({out_valid, dmem_req, stall_out, reg_w_out} !== 4'b1001) begin
      errors++;
      $display("FAIL load_done_ctrl got %b want 1001",
               {out_valid, dmem_req, stall_out, reg_w_out});
    end
    checks++;
    if (wb_data_out !== 32'hDEADBEEF || rd_out !== 5'd7) begin
      errors++;
      $display("FAIL load_done_data got %h/%0d want deadbeef/7", wb_data_out, rd_out);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_pulse got %b want 0", out_valid);
    end
  endtask

  task automatic test_store();
    drive(1'b1, 32'h80, 32'h1234, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checks++;
    if ({dmem_req, dmem_we, stall_out} !== 3'b111 || dmem_wdata !== 32'h1234
        || dmem_addr !== 32'h80) begin
      errors++;
      $display("FAIL store_req got rws=%b wd=%h a=%h want 111 wd=1234 a=80",
               {dmem_req, dmem_we, stall_out}, dmem_wdata, dmem_addr);
    end
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF_0000;
    in_valid   = 1'b0;
    tick();
    dmem_ack = 1'b0;
    checks++;
    if ({out_valid, reg_w_out, dmem_req, timeout_err} !== 4'b1000 || wb_data_out !== 32'h80) begin
      errors++;
      $display("FAIL store_done got vwrt=%b d=%h want 1000 d=80",
               {out_valid, reg_w_out, dmem_req, timeout_err}, wb_data_out);
    end
    // Load and store both set: behaves as store, read data unused.
    drive(1'b1, 32'h84, 32'hABCD, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    checks++;
    if (dmem_we !== 1'b1 || dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL both_we got we=%b req=%b want 1 1", dmem_we, dmem_req);
    end
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    in_valid   = 1'b0;
    tick();
    dmem_ack = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || wb_data_out !== 32'h84 || reg_w_out !== 1'b1) begin
      errors++;
      $display("FAIL both_done got v=%b d=%h w=%b want 1 84 1", out_valid, wb_data_out, reg_w_out);
    end
  endtask

  task automatic test_ack_at_expiry();
    drive(1'b1, 32'h48, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    // Fourth ACCESS cycle: counter at its limit, ack arrives together.
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h1357_9BDF;
    tick();
    dmem_ack = 1'b0;
    checks++;
    if ({out_valid, reg_w_out, timeout_err} !== 3'b110 || wb_data_out !== 32'h1357_9BDF) begin
      errors++;
      $display("FAIL ack_expiry got vwt=%b d=%h want 110 d=13579bdf",
               {out_valid, reg_w_out, timeout_err}, wb_data_out);
    end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    drive(1'b1, 32'h44, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    // Bounded wait for the request to drop.
    for (int i = 0; i < 10 && dmem_req === 1'b1; i++) begin
      req_cycles++;
      tick();
    end
    checks++;
    if (req_cycles != 4) begin
      errors++;
      $display("FAIL timeout_req_cycles got %0d want 4", req_cycles);
    end
    checks++;
    if ({dmem_req, timeout_err, out_valid, reg_w_out, stall_out} !== 5'b01100) begin
      errors++;
      $display("FAIL timeout_abort got rtvws=%b want 01100",
               {dmem_req, timeout_err, out_valid, reg_w_out, stall_out});
    end
    tick();
    tick();
    checks++;
    if (timeout_err !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_sticky got t=%b v=%b want 1 0", timeout_err, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h50, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre got req=%b want 1", dmem_req);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({dmem_req, stall_out, out_valid, timeout_err} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid got rsvt=%b want 0000", {dmem_req, stall_out, out_valid, timeout_err});
    end
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_discard got v=%b want 0", out_valid);
    end
    drive(1'b1, 32'h11, 32'h0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || wb_data_out !== 32'h11 || rd_out !== 5'd2 || reg_w_out !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_alu got v=%b d=%h rd=%0d w=%b want 1 11 2 1",
               out_valid, wb_data_out, rd_out, reg_w_out);
    end
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic test_misalign();
    drive(1'b1, 32'h42, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({dmem_req, stall_out, misalign_err, out_valid, reg_w_out} !== 5'b00110) begin
      errors++;
      $display("FAIL misalign got rsmvw=%b want 00110",
               {dmem_req, stall_out, misalign_err, out_valid, reg_w_out});
    end
    tick();
    checks++;
    if (dmem_req !== 1'b0 || misalign_err !== 1'b1) begin
      errors++;
      $display("FAIL misalign_sticky got r=%b m=%b want 0 1", dmem_req, misalign_err);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_ack_at_expiry();
    test_timeout();
    test_reset_mid();
`ifdef MEM_ALIGN_CHECK_EN
    test_misalign();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage, directly downstream of the execute stage.
- Consumes the ALU result, store data, destination register and control bits (mem_R, mem_W, WB, RegW). Performs the data-memory access over a req/ack handshake and presents registered write-back data to the WB stage.
- Stalls upstream while a memory access is outstanding.
- Aborts any access that exceeds a timeout.

Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles dmem_req stays high without dmem_ack before the access is aborted. Must be at least 1.
- ADDR_W, 32, width of dmem_addr, taken from alu_res_in[ADDR_W-1:0].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  execute stage presents an instruction.
- alu_res_in  in  32  ALU result; used as memory address or as pass-through data.
- store_data_in  in  32  Op2 value, used as store data.
- rd_in  in  5  destination register.
- mem_r_in  in  1  load.
- mem_w_in  in  1  store.
- wb_sel_in  in  1  1 selects memory read data for write-back; 0 selects the ALU result.
- reg_w_in  in  1  register write enable.
- stall_out  out  1  high while state is not IDLE; upstream must hold its outputs.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write enable, valid only while dmem_req is high.
- dmem_addr  out  ADDR_W  address.
- dmem_wdata  out  32  store data.
- dmem_rdata  in  32  read data, sampled in the cycle dmem_ack is high.
- dmem_ack  in  1  one-cycle completion pulse.
- out_valid  out  1  one-cycle pulse; write-back outputs are valid.
- wb_data_out  out  32  write-back data.
- rd_out  out  5  destination register.
- reg_w_out  out  1  register write enable to the WB stage.
- timeout_err  out  1  sticky abort flag.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE.
  - All outputs 0: stall_out, dmem_req, dmem_we, dmem_addr, dmem_wdata, out_valid, wb_data_out, rd_out, reg_w_out, timeout_err.
  - The timeout counter clears.
  - Reset during ACCESS drops dmem_req at that edge; the in-flight instruction is discarded with no out_valid.
- States: IDLE, ACCESS.
- IDLE, in_valid=1, mem_r_in=0, mem_w_in=0: next edge drives out_valid=1, wb_data_out=alu_res_in, rd_out=rd_in, reg_w_out=reg_w_in. Latency is 1 cycle and throughput is 1 per cycle.
- IDLE, in_valid=1, mem_r_in or mem_w_in set: next edge captures all inputs.
  - Drive dmem_req=1, dmem_addr=alu_res_in, dmem_wdata=store_data_in, dmem_we=mem_w_in.
  - Go to ACCESS; counter=0; out_valid=0.
- mem_r_in and mem_w_in both set: treated as a store; no read data is used.
- IDLE, in_valid=0: out_valid=0; all other outputs hold their values.
- ACCESS:
  - stall_out=1.
  - dmem_req, dmem_addr, dmem_wdata and dmem_we are held stable.
  - Inputs are ignored.
  - The counter increments each cycle that dmem_ack=0.
- dmem_ack=1 in ACCESS: next edge:
  - dmem_req=0, out_valid=1, state=IDLE.
  - wb_data_out = dmem_rdata if (wb_sel_in and load) else the captured alu_res_in.
  - rd_out and reg_w_out come from the captured values.
  - Minimum memory-op latency is 2 cycles: accept, then an ack in the first ACCESS cycle.
- Timeout: counter reaches TIMEOUT_CYCLES-1 with dmem_ack=0. Next edge:
  - dmem_req=0, timeout_err=1 (sticky until reset).
  - out_valid=1 with reg_w_out=0.
  - state=IDLE.
- If dmem_ack arrives in the same cycle the counter expires, the ack wins: normal completion and no error.
- dmem_ack while in IDLE is ignored.
- reg_w_out is forced to 0 whenever rd is 0.
- stall_out is registered; it rises the cycle after a memory op is accepted. The execute stage's output register holds while stall_out=1.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - A memory op whose alu_res_in[1:0]!=0 is not issued: dmem_req stays 0 and the state stays IDLE.
  - Next edge: out_valid=1 and reg_w_out=0.
  - Adds output misalign_err (1 bit, sticky until reset, reset value 0), set on that edge.
- Undefined:
  - No misalign_err port.
  - Addresses are passed through unchecked.

Test Plan:
- ALU pass-through: in_valid=1, alu_res_in=0x0000_0005, rd_in=3, reg_w_in=1, no mem op -> next cycle out_valid=1, wb_data_out=5, rd_out=3, reg_w_out=1, stall_out=0.
- Load: alu_res_in=0x40, mem_r_in=1, wb_sel_in=1, rd_in=7; ack after 3 cycles with dmem_rdata=0xDEADBEEF.
  - dmem_req=1, dmem_addr=0x40, dmem_we=0 for 3 cycles; stall_out=1 throughout.
  - Then out_valid=1, wb_data_out=0xDEADBEEF, rd_out=7.
- Store: alu_res_in=0x80, store_data_in=0x1234, mem_w_in=1, reg_w_in=0; immediate ack -> dmem_we=1, dmem_wdata=0x1234 for one cycle; out_valid=1, reg_w_out=0.
- Timeout: TIMEOUT_CYCLES=4, load, no ack -> dmem_req high 4 cycles then low; timeout_err=1 stays high; out_valid=1 with reg_w_out=0.
- Reset mid-access: rst=1 during ACCESS -> next edge dmem_req=0, stall_out=0, no out_valid; a following ALU op completes normally.
- With MEM_ALIGN_CHECK_EN: load at 0x42 -> dmem_req never asserts; misalign_err=1; out_valid=1 with reg_w_out=0.
